// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative radix-2 multiply/divide engine for the HI/LO pair.
//   A start in IDLE latches the operands. PREP takes magnitudes. CALC runs one
//   bit per cycle for DATA_WIDTH cycles. FIX applies the sign correction and
//   registers the result. Done arrives DATA_WIDTH+3 edges after the start edge.
// Optional feature macro: MULT_DIV_SIGNED_EN
//   Defined:   signed_op selects two's-complement MULT/DIV.
//   Undefined: every operation is unsigned. Latency is the same either way.
// Ports:
//   CLK, RST                 rising-edge clock, async active-high reset
//   mult_start, div_start    start requests (multiply wins if both are high)
//   signed_op                signed operation select, latched with start
//   op_a, op_b               multiplicand/dividend, multiplier/divisor
//   hi_out, lo_out           product high/low, or remainder/quotient
//   busy                     operation in flight
//   mult_div_done            one-cycle completion pulse
//   div_by_zero              sticky flag, cleared by the next start
module mult_div_unit #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  mult_start,
  input  logic                  div_start,
  input  logic                  signed_op,
  input  logic [DATA_WIDTH-1:0] op_a,
  input  logic [DATA_WIDTH-1:0] op_b,
  output logic [DATA_WIDTH-1:0] hi_out,
  output logic [DATA_WIDTH-1:0] lo_out,
  output logic                  busy,
  output logic                  mult_div_done,
  output logic                  div_by_zero
);

  localparam int unsigned W  = DATA_WIDTH;
  localparam int unsigned CW = $clog2(W + 1);

`ifdef MULT_DIV_SIGNED_EN
  localparam bit SIGNED_EN = 1'b1;
`else
  localparam bit SIGNED_EN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, PREP, CALC, FIX} state_t;

  state_t        state;
  logic          is_div;
  logic          sgn_op;
  logic          neg_res;
  logic          neg_rem;
  logic [W-1:0]  a_reg;
  logic [W-1:0]  b_reg;
  logic [W-1:0]  mag;      // multiplicand or divisor magnitude
  logic [W-1:0]  acc_hi;   // product high half / partial remainder
  logic [W-1:0]  acc_lo;   // multiplier, then product low / dividend, then quotient
  logic [CW-1:0] cnt;

  logic          signed_req;
  logic [W-1:0]  mag_a;
  logic [W-1:0]  mag_b;
  logic [W:0]    mul_sum;
  logic [W:0]    div_shift;
  logic [W:0]    div_diff;
  logic [2*W-1:0] prod;
  logic [2*W-1:0] prod_fix;
  logic [W-1:0]  quo_fix;
  logic [W-1:0]  rem_fix;

  assign signed_req = signed_op & SIGNED_EN;

  // Datapath for one iteration and for the final sign correction
  always_comb begin
    mag_a     = (sgn_op && a_reg[W-1]) ? (W'(0) - a_reg) : a_reg;
    mag_b     = (sgn_op && b_reg[W-1]) ? (W'(0) - b_reg) : b_reg;
    mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mag} : (W+1)'(0));
    div_shift = {acc_hi, acc_lo[W-1]};
    div_diff  = div_shift - {1'b0, mag};
    prod      = {acc_hi, acc_lo};
    prod_fix  = neg_res ? ((2*W)'(0) - prod) : prod;
    quo_fix   = neg_res ? (W'(0) - acc_lo) : acc_lo;
    rem_fix   = neg_rem ? (W'(0) - acc_hi) : acc_hi;
  end

  // Sequence controller and result registers
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state         <= IDLE;
      is_div        <= 1'b0;
      sgn_op        <= 1'b0;
      neg_res       <= 1'b0;
      neg_rem       <= 1'b0;
      a_reg         <= '0;
      b_reg         <= '0;
      mag           <= '0;
      acc_hi        <= '0;
      acc_lo        <= '0;
      cnt           <= '0;
      hi_out        <= '0;
      lo_out        <= '0;
      busy          <= 1'b0;
      mult_div_done <= 1'b0;
      div_by_zero   <= 1'b0;
    end else begin
      mult_div_done <= 1'b0;
      case (state)
        IDLE: begin
          if (mult_start || div_start) begin
            is_div      <= ~mult_start;
            sgn_op      <= signed_req;
            a_reg       <= op_a;
            b_reg       <= op_b;
            div_by_zero <= 1'b0;
            busy        <= 1'b1;
            state       <= PREP;
          end
        end
        PREP: begin
          if (is_div) begin
            mag    <= mag_b;
            acc_lo <= mag_a;
          end else begin
            mag    <= mag_a;
            acc_lo <= mag_b;
          end
          acc_hi  <= '0;
          neg_res <= sgn_op & (a_reg[W-1] ^ b_reg[W-1]);
          neg_rem <= sgn_op & a_reg[W-1];
          cnt     <= CW'(W);
          state   <= CALC;
        end
        CALC: begin
          if (is_div) begin
            // Restoring step: keep the difference only when it did not borrow
            if (!div_diff[W]) begin
              acc_hi <= div_diff[W-1:0];
              acc_lo <= {acc_lo[W-2:0], 1'b1};
            end else begin
              acc_hi <= div_shift[W-1:0];
              acc_lo <= {acc_lo[W-2:0], 1'b0};
            end
          end else begin
            acc_hi <= mul_sum[W:1];
            acc_lo <= {mul_sum[0], acc_lo[W-1:1]};
          end
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) state <= FIX;
        end
        FIX: begin
          if (is_div) begin
            if (b_reg == '0) begin
              hi_out      <= a_reg;
              lo_out      <= '1;
              div_by_zero <= 1'b1;
            end else begin
              hi_out <= rem_fix;
              lo_out <= quo_fix;
            end
          end else begin
            hi_out <= prod_fix[2*W-1:W];
            lo_out <= prod_fix[W-1:0];
          end
          mult_div_done <= 1'b1;
          busy          <= 1'b0;
          state         <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit (DATA_WIDTH = 32). Expected values are
// hand-computed; signed cases select their constants from MULT_DIV_SIGNED_EN.
module tb_mult_div_unit;

  logic        CLK;
  logic        RST;
  logic        mult_start;
  logic        div_start;
  logic        signed_op;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [31:0] hi_out;
  logic [31:0] lo_out;
  logic        busy;
  logic        mult_div_done;
  logic        div_by_zero;

  int n_checks;
  int n_fail;

  // Results captured by run_op
  int          lat;
  int          dones;
  int          busy_bad;
  logic        dbz_at1;
  logic [31:0] cap_hi;
  logic [31:0] cap_lo;
  logic        cap_dbz;

  mult_div_unit #(.DATA_WIDTH(32)) dut (
    .CLK           (CLK),
    .RST           (RST),
    .mult_start    (mult_start),
    .div_start     (div_start),
    .signed_op     (signed_op),
    .op_a          (op_a),
    .op_b          (op_b),
    .hi_out        (hi_out),
    .lo_out        (lo_out),
    .busy          (busy),
    .mult_div_done (mult_div_done),
    .div_by_zero   (div_by_zero)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Issue one start and watch 60 cycles; optionally re-pulse a start or RST.
  task automatic run_op(input logic m, input logic d, input logic s,
                        input logic [31:0] a, input logic [31:0] b,
                        input int inj_start, input int inj_rst);
    @(negedge CLK);
    mult_start = m;
    div_start  = d;
    signed_op  = s;
    op_a       = a;
    op_b       = b;
    lat      = -1;
    dones    = 0;
    busy_bad = 0;
    dbz_at1  = 1'bx;
    cap_hi   = '0;
    cap_lo   = '0;
    cap_dbz  = 1'b0;
    for (int n = 1; n <= 60; n++) begin
      @(posedge CLK);
      @(negedge CLK);
      if (n == 1) begin
        mult_start = 1'b0;
        div_start  = 1'b0;
        op_a       = $urandom;
        op_b       = $urandom;
        dbz_at1    = div_by_zero;
      end
      if (mult_div_done) begin
        dones++;
        if (lat < 0) begin
          lat     = n;
          cap_hi  = hi_out;
          cap_lo  = lo_out;
          cap_dbz = div_by_zero;
          if (busy) busy_bad++;
        end
      end else if (lat < 0 && inj_rst == 0 && !busy) begin
        busy_bad++;
      end
      if (n == inj_start)     mult_start = 1'b1;
      if (n == inj_start + 1) mult_start = 1'b0;
      if (n == inj_rst)       RST = 1'b1;
      if (n == inj_rst + 1)   RST = 1'b0;
    end
  endtask

  initial begin
    logic [31:0] e_hi;
    logic [31:0] e_lo;
    n_checks   = 0;
    n_fail     = 0;
    RST        = 1'b1;
    mult_start = 1'b0;
    div_start  = 1'b0;
    signed_op  = 1'b0;
    op_a       = '0;
    op_b       = '0;
    repeat (3) @(negedge CLK);
    check("rst_hi",   64'(hi_out), 64'h0);
    check("rst_lo",   64'(lo_out), 64'h0);
    check("rst_busy", 64'(busy), 64'h0);
    check("rst_done", 64'(mult_div_done), 64'h0);
    check("rst_dbz",  64'(div_by_zero), 64'h0);
    RST = 1'b0;

    // Unsigned multiply, full-scale operands
    run_op(1'b1, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0);
    check("mulu_lat",   64'(lat), 64'd35);
    check("mulu_hi",    64'(cap_hi), 64'hFFFF_FFFE);
    check("mulu_lo",    64'(cap_lo), 64'h0000_0001);
    check("mulu_busy",  64'(busy_bad), 64'd0);
    check("mulu_dones", 64'(dones), 64'd1);
    check("mulu_hold",  64'({hi_out, lo_out}), 64'hFFFF_FFFE_0000_0001);

    // Signed multiply -3 x 5
`ifdef MULT_DIV_SIGNED_EN
    e_hi = 32'hFFFF_FFFF;
`else
    e_hi = 32'h0000_0004;
`endif
    run_op(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFD, 32'd5, 0, 0);
    check("muls_hi", 64'(cap_hi), 64'(e_hi));
    check("muls_lo", 64'(cap_lo), 64'hFFFF_FFF1);

    // Signed divide -7 / 2
`ifdef MULT_DIV_SIGNED_EN
    e_hi = 32'hFFFF_FFFF; e_lo = 32'hFFFF_FFFD;
`else
    e_hi = 32'h0000_0001; e_lo = 32'h7FFF_FFFC;
`endif
    run_op(1'b0, 1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2, 0, 0);
    check("divs_hi", 64'(cap_hi), 64'(e_hi));
    check("divs_lo", 64'(cap_lo), 64'(e_lo));

    // MIN / -1
`ifdef MULT_DIV_SIGNED_EN
    e_hi = 32'h0000_0000; e_lo = 32'h8000_0000;
`else
    e_hi = 32'h8000_0000; e_lo = 32'h0000_0000;
`endif
    run_op(1'b0, 1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
    check("minneg1_hi",  64'(cap_hi), 64'(e_hi));
    check("minneg1_lo",  64'(cap_lo), 64'(e_lo));
    check("minneg1_dbz", 64'(cap_dbz), 64'h0);

    // Unsigned divide
    run_op(1'b0, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'h0000_0010, 0, 0);
    check("divu_hi", 64'(cap_hi), 64'h0000_000F);
    check("divu_lo", 64'(cap_lo), 64'h0FFF_FFFF);

    // Divide by zero, then the next start clears the flag at E0
    run_op(1'b0, 1'b1, 1'b0, 32'd100, 32'd0, 0, 0);
    check("dbz_hi",   64'(cap_hi), 64'h0000_0064);
    check("dbz_lo",   64'(cap_lo), 64'hFFFF_FFFF);
    check("dbz_flag", 64'(cap_dbz), 64'h1);
    check("dbz_held", 64'(div_by_zero), 64'h1);
    run_op(1'b1, 1'b0, 1'b0, 32'd2, 32'd3, 0, 0);
    check("dbz_clr", 64'(dbz_at1), 64'h0);
    check("mul6_lo", 64'(cap_lo), 64'd6);

    // Signed divide by zero keeps the raw dividend in HI
    run_op(1'b0, 1'b1, 1'b1, 32'hFFFF_FFF9, 32'd0, 0, 0);
    check("dbzs_hi",   64'(cap_hi), 64'hFFFF_FFF9);
    check("dbzs_lo",   64'(cap_lo), 64'hFFFF_FFFF);
    check("dbzs_flag", 64'(cap_dbz), 64'h1);

    // Both starts together: multiply wins
    run_op(1'b1, 1'b1, 1'b0, 32'd6, 32'd7, 0, 0);
    check("both_hi", 64'(cap_hi), 64'd0);
    check("both_lo", 64'(cap_lo), 64'd42);

    // Start pulsed while busy is ignored
    run_op(1'b1, 1'b0, 1'b0, 32'd10, 32'd20, 5, 0);
    check("ign_dones", 64'(dones), 64'd1);
    check("ign_lo",    64'(cap_lo), 64'd200);
    check("ign_busy",  64'(busy), 64'h0);

    // Reset mid-operation
    run_op(1'b1, 1'b0, 1'b0, 32'd11, 32'd13, 0, 10);
    check("rstm_dones", 64'(dones), 64'd0);
    check("rstm_hi",    64'(hi_out), 64'h0);
    check("rstm_lo",    64'(lo_out), 64'h0);
    check("rstm_busy",  64'(busy), 64'h0);

    // Operation after reset completes normally
    run_op(1'b0, 1'b1, 1'b0, 32'd9, 32'd2, 0, 0);
    check("post_lat",  64'(lat), 64'd35);
    check("post_hi",   64'(cap_hi), 64'd1);
    check("post_lo",   64'(cap_lo), 64'd4);
    check("post_busy", 64'(busy_bad), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Parametrised iterative multiply/divide unit feeding the HI/LO registers of the multi-cycle MIPS core. The sequence controller starts it with `mult_start` or `div_start` and stalls until `mult_div_done`. It replaces the fixed 32-bit, unsigned-only arrangement with a width-generic radix-2 engine. It adds signed operation, a defined divide-by-zero result, and a busy indication.

## Interface
- `DATA_WIDTH`, 32, operand width W; HI/LO are each W bits; W ≥ 4.
- `CLK` input 1: rising-edge clock.
- `RST` input 1: asynchronous, active-high reset.
- `mult_start` input 1: start multiply; sampled only in IDLE.
- `div_start` input 1: start divide; sampled only in IDLE.
- `signed_op` input 1: 1 = MULT/DIV (two's complement), 0 = MULTU/DIVU; latched with start.
- `op_a` input W: multiplicand / dividend; latched with start.
- `op_b` input W: multiplier / divisor; latched with start.
- `hi_out` output W: product high half / remainder.
- `lo_out` output W: product low half / quotient.
- `busy` output 1: operation in flight.
- `mult_div_done` output 1: one-cycle completion pulse.
- `div_by_zero` output 1: sticky until next start; set when a divide completes with `op_b`=0.

## Operation
- States: IDLE → PREP → CALC → FIX → IDLE.
- IDLE, start seen at edge E0:
  - latch operands, `signed_op` and op type; clear `div_by_zero`; go to PREP.
  - `mult_start` and `div_start` both high: multiply wins, divide request dropped.
- PREP (edge E1): take operand magnitudes when signed; record result sign and remainder sign; load iteration counter with W.
- CALC (edges E2…E(W+1)): one bit per cycle.
  - Multiply: shift-add into a 2W accumulator.
  - Divide: restoring shift-subtract on a W+1 bit partial remainder.
  - Counter decrements each cycle; leave CALC when it reaches 0.
- FIX (edge E(W+2)): apply sign correction; register `hi_out`/`lo_out`; pulse `mult_div_done`; return to IDLE.
- Signed rules:
  - Product is the exact 2W two's-complement result.
  - Quotient truncates toward zero; remainder takes the dividend's sign.
  - MIN / −1 gives LO = MIN, HI = 0; no trap.
- Divide by zero: HI = latched `op_a`, LO = all ones, `div_by_zero` = 1. This applies in both signed and unsigned modes.
- `hi_out`/`lo_out` hold their value until the next FIX. They never change mid-operation.
- Starts seen while `busy` = 1 are ignored, not queued.

## Timing
- Reset values: `hi_out` = 0, `lo_out` = 0, `busy` = 0, `mult_div_done` = 0, `div_by_zero` = 0, state IDLE.
- Latency: `mult_div_done` goes high in the cycle after edge E(W+2), i.e. W+3 edges after the sampling edge (35 for W = 32). It lasts exactly one cycle.
- `hi_out`, `lo_out` and `div_by_zero` are valid in the same cycle as `mult_div_done`.
- `busy` timing:
  - rises after E0;
  - falls after E(W+2), in the same cycle that `mult_div_done` is high (`busy` = 0 there);
  - a new start is accepted in that cycle, so back-to-back throughput is W+3 cycles.
- Operand inputs may change freely after E0.
- `RST` mid-operation: immediate return to IDLE, all outputs zeroed, no done pulse.

## Configuration
- `MULT_DIV_SIGNED_EN`:
  - Defined: `signed_op` is honoured per the signed rules above.
  - Undefined: `signed_op` is ignored and every operation is unsigned. PREP still takes one cycle, so latency is unchanged.

## Test plan
- Unsigned multiply: `mult_start`, `signed_op`=0, 0xFFFFFFFF × 0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001; done pulse 35 edges after start; `busy` high throughout.
- Signed multiply: `signed_op`=1, −3 × 5 → HI=0xFFFFFFFF, LO=0xFFFFFFF1. Without the macro: HI=0x00000004, LO=0xFFFFFFF1.
- Signed divide:
  - −7 / 2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0x00000000.
- Divide by zero: `div_start`, 100 / 0 → HI=0x00000064, LO=0xFFFFFFFF, `div_by_zero`=1. The next start clears the flag at E0.
- Hazards:
  - `mult_start` and `div_start` high together → multiply result.
  - A start pulsed at cycle 5 while busy → ignored, single done pulse.
  - `RST` at cycle 10 → outputs 0, no done, next start completes normally.
